// File: rtl/cavlc_scan_ctrl.sv
// Reverse-zigzag scan sequencer for CAVLC statistics: drives the shared coefficient counter and tracks TotalZeros.
// TrailingOnes/sign tracking is present only when CAVLC_T1_DETECT_EN is defined.
module cavlc_scan_ctrl #(
  parameter int COEFF_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               h264_reset,
  input  logic               start_i,
  input  logic [1:0]         block_type_i,
  output logic               start_ready_o,
  output logic               coeff_rd_o,
  output logic [3:0]         coeff_addr_o,
  input  logic [COEFF_W-1:0] coeff_rdata_i,
  output logic               cnt_rst_o,
  output logic               start_cnt_o,
  output logic [COEFF_W-1:0] coeff_o,
  input  logic [4:0]         total_coeff_cnt_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [4:0]         total_coeff_o,
  output logic [1:0]         trailing_ones_o,
  output logic [2:0]         t1_signs_o,
  output logic [3:0]         total_zeros_o,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SCAN  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic       bot_q, bot_d;
  logic       seen_nz_q, seen_nz_d;
  logic [3:0] tz_q, tz_d;

  logic srst;
  logic fwd;
  logic nz;

  assign srst = rst | h264_reset;
  // Data returned for the previous cycle's read is consumed in SCAN and DRAIN.
  assign fwd  = (state_q == SCAN) || (state_q == DRAIN);
  assign nz   = |coeff_rdata_i;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= IDLE;
      addr_q    <= 4'd0;
      bot_q     <= 1'b0;
      seen_nz_q <= 1'b0;
      tz_q      <= 4'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      bot_q     <= bot_d;
      seen_nz_q <= seen_nz_d;
      tz_q      <= tz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bot_d     = bot_q;
    seen_nz_d = seen_nz_q;
    tz_d      = tz_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CLR;
          addr_d  = (block_type_i == 2'd2) ? 4'd3 : 4'd15;
          bot_d   = (block_type_i == 2'd1);
        end
      end
      CLR: begin
        state_d   = SCAN;
        addr_d    = addr_q - 4'd1;
        seen_nz_d = 1'b0;
        tz_d      = 4'd0;
      end
      SCAN: begin
        addr_d = addr_q - 4'd1;
        if (addr_q == {3'b000, bot_q}) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fwd) begin
      if (nz) seen_nz_d = 1'b1;
      else if (seen_nz_q && (tz_q != 4'd15)) tz_d = tz_q + 4'd1;
    end
  end

`ifdef CAVLC_T1_DETECT_EN
  logic       t1_open_q, t1_open_d;
  logic [1:0] t1_cnt_q, t1_cnt_d;
  logic [2:0] t1_sgn_q, t1_sgn_d;
  logic       is_one;

  assign is_one = (coeff_rdata_i == COEFF_W'(1)) || (&coeff_rdata_i);

  always_ff @(posedge clk) begin
    if (srst) begin
      t1_open_q <= 1'b0;
      t1_cnt_q  <= 2'd0;
      t1_sgn_q  <= 3'd0;
    end else begin
      t1_open_q <= t1_open_d;
      t1_cnt_q  <= t1_cnt_d;
      t1_sgn_q  <= t1_sgn_d;
    end
  end

  // Zeros leave the window open; any other nonzero or the third +/-1 closes it.
  always_comb begin
    t1_open_d = t1_open_q;
    t1_cnt_d  = t1_cnt_q;
    t1_sgn_d  = t1_sgn_q;
    if (state_q == CLR) begin
      t1_open_d = 1'b1;
      t1_cnt_d  = 2'd0;
      t1_sgn_d  = 3'd0;
    end else if (fwd && t1_open_q && nz) begin
      if (is_one && (t1_cnt_q != 2'd3)) begin
        case (t1_cnt_q)
          2'd0:    t1_sgn_d[0] = coeff_rdata_i[COEFF_W-1];
          2'd1:    t1_sgn_d[1] = coeff_rdata_i[COEFF_W-1];
          default: t1_sgn_d[2] = coeff_rdata_i[COEFF_W-1];
        endcase
        t1_cnt_d = t1_cnt_q + 2'd1;
        if (t1_cnt_q == 2'd2) t1_open_d = 1'b0;
      end else begin
        t1_open_d = 1'b0;
      end
    end
  end
`endif

  always_comb begin
    start_ready_o   = 1'b0;
    busy_o          = 1'b0;
    cnt_rst_o       = 1'b0;
    coeff_rd_o      = 1'b0;
    coeff_addr_o    = 4'd0;
    start_cnt_o     = 1'b0;
    coeff_o         = '0;
    out_valid_o     = 1'b0;
    total_coeff_o   = 5'd0;
    trailing_ones_o = 2'd0;
    t1_signs_o      = 3'd0;
    total_zeros_o   = 4'd0;
    case (state_q)
      IDLE: start_ready_o = 1'b1;
      CLR: begin
        busy_o       = 1'b1;
        cnt_rst_o    = 1'b1;
        coeff_rd_o   = 1'b1;
        coeff_addr_o = addr_q;
      end
      SCAN: begin
        busy_o       = 1'b1;
        coeff_rd_o   = 1'b1;
        coeff_addr_o = addr_q;
        start_cnt_o  = 1'b1;
        coeff_o      = coeff_rdata_i;
      end
      DRAIN: begin
        busy_o      = 1'b1;
        start_cnt_o = 1'b1;
        coeff_o     = coeff_rdata_i;
      end
      DONE: begin
        busy_o        = 1'b1;
        out_valid_o   = 1'b1;
        total_coeff_o = total_coeff_cnt_i;
        total_zeros_o = tz_q;
`ifdef CAVLC_T1_DETECT_EN
        trailing_ones_o = t1_cnt_q;
        t1_signs_o      = t1_sgn_q;
`endif
      end
      default: ;
    endcase
  end

endmodule
